// File: rtl/upsample_stream.sv
// 2x nearest-neighbour upsampler: snapshots a pooled map and streams the enlarged,
// optionally cropped, map in raster order over a valid/ready handshake.
module upsample_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_SIZE    = 14,
    parameter int OUT_SIZE   = 28
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [DATA_WIDTH-1:0]       in_map [IN_SIZE][IN_SIZE],
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [$clog2(OUT_SIZE)-1:0] out_row,
    output logic [$clog2(OUT_SIZE)-1:0] out_col,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int CW = $clog2(OUT_SIZE);
    localparam logic [CW-1:0] LAST = CW'(OUT_SIZE - 1);

    generate
        if (IN_SIZE < 2 || (OUT_SIZE != 2*IN_SIZE && OUT_SIZE != 2*IN_SIZE-1)) begin : g_bad_size
            $error("upsample_stream: OUT_SIZE must be 2*IN_SIZE or 2*IN_SIZE-1 with IN_SIZE >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_WIDTH-1:0]   snap [IN_SIZE][IN_SIZE];
    logic                    hs;
    logic                    col_wrap;
    logic [CW-1:0]           row_nxt;
    logic [CW-1:0]           col_nxt;

    assign hs       = out_valid & out_ready;
    assign col_wrap = (out_col == LAST);

    // Raster advance: column first, row on column wrap.
    always_comb begin
        col_nxt = col_wrap ? '0 : out_col + 1'b1;
        row_nxt = col_wrap ? out_row + 1'b1 : out_row;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = LOAD;
            LOAD:    state_nxt = STREAM;
            STREAM: begin
                if (hs && out_last) state_nxt = DONE;
                else if (!en)       state_nxt = IDLE;
            end
            DONE:    if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot isolates the stream from later changes on in_map.
    always_ff @(posedge clk) begin
        if (state == LOAD) snap <= in_map;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt == STREAM);
            busy      <= (state_nxt == LOAD) || (state_nxt == STREAM);
            done      <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    out_row  <= '0;
                    out_col  <= '0;
                    out_last <= 1'b0;
                end
                LOAD: begin
                    // Snapshot is not written yet, so pixel (0,0) comes straight from in_map.
                    out_data <= in_map[0][0];
                    out_row  <= '0;
                    out_col  <= '0;
                    out_last <= 1'b0;
                end
                STREAM: begin
                    if (state_nxt == STREAM) begin
                        if (hs) begin
                            out_row  <= row_nxt;
                            out_col  <= col_nxt;
                            out_data <= snap[row_nxt[CW-1:1]][col_nxt[CW-1:1]];
                            out_last <= (row_nxt == LAST) && (col_nxt == LAST);
                        end
                    end else if (state_nxt == IDLE) begin
                        out_row  <= '0;
                        out_col  <= '0;
                        out_last <= 1'b0;
                    end else begin
                        out_last <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_upsample_stream.sv
// Directed bench for upsample_stream: a 2->4 instance and a 3->5 (cropped) instance.
module tb_upsample_stream;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          en_a, rdy_a;
    logic [DW-1:0] map_a [2][2];
    logic [DW-1:0] data_a;
    logic [1:0]    row_a, col_a;
    logic          valid_a, last_a, busy_a, done_a;

    logic          en_b, rdy_b;
    logic [DW-1:0] map_b [3][3];
    logic [DW-1:0] data_b;
    logic [2:0]    row_b, col_b;
    logic          valid_b, last_b, busy_b, done_b;

    upsample_stream #(.DATA_WIDTH(DW), .IN_SIZE(2), .OUT_SIZE(4)) dut_a (
        .clk(clk), .reset(reset), .en(en_a), .in_map(map_a),
        .out_data(data_a), .out_row(row_a), .out_col(col_a), .out_valid(valid_a),
        .out_ready(rdy_a), .out_last(last_a), .busy(busy_a), .done(done_a)
    );

    upsample_stream #(.DATA_WIDTH(DW), .IN_SIZE(3), .OUT_SIZE(5)) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .in_map(map_b),
        .out_data(data_b), .out_row(row_b), .out_col(col_b), .out_valid(valid_b),
        .out_ready(rdy_b), .out_last(last_b), .busy(busy_b), .done(done_b)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   sel_b    = 1'b0;
    int   side;
    int   exp_pix [25];

    logic [31:0] o_data, o_row, o_col;
    logic        o_valid, o_last, o_busy, o_done;

    assign o_data  = sel_b ? 32'(data_b) : 32'(data_a);
    assign o_row   = sel_b ? 32'(row_b)  : 32'(row_a);
    assign o_col   = sel_b ? 32'(col_b)  : 32'(col_a);
    assign o_valid = sel_b ? valid_b : valid_a;
    assign o_last  = sel_b ? last_b  : last_a;
    assign o_busy  = sel_b ? busy_b  : busy_a;
    assign o_done  = sel_b ? done_b  : done_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic rdy);
        if (sel_b) begin
            en_b  = en;
            rdy_b = rdy;
        end else begin
            en_a  = en;
            rdy_a = rdy;
        end
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
    task automatic run_frame(input string tag, input int n_pix, input int mode,
                             input bit clobber, input int abort_after, input int exp_lat);
        int   edges;
        int   hs_n;
        int   cyc;
        logic rdy;
        edges = 0;
        hs_n  = 0;
        cyc   = 0;
        drive(1'b1, 1'b1);
        step(); edges++;
        check({tag, " load_busy"}, 32'(o_busy), 1);
        check({tag, " load_valid"}, 32'(o_valid), 0);
        step(); edges++;
        if (clobber) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    map_a[i][j] = 8'hFF;
        end
        while (hs_n < n_pix && cyc < 200 && !(abort_after > 0 && hs_n == abort_after)) begin
            rdy = (mode == 0) || (cyc % 3 == 0);
            drive(1'b1, rdy);
            check({tag, " valid"}, 32'(o_valid), 1);
            check({tag, " data"}, o_data, exp_pix[hs_n]);
            check({tag, " row"}, o_row, hs_n / side);
            check({tag, " col"}, o_col, hs_n % side);
            check({tag, " last"}, 32'(o_last), 32'(hs_n == n_pix - 1));
            if (rdy) hs_n++;
            step(); edges++; cyc++;
        end
        if (abort_after > 0) begin
            check({tag, " abort_point"}, hs_n, abort_after);
        end else begin
            check({tag, " handshakes"}, hs_n, n_pix);
            check({tag, " done"}, 32'(o_done), 1);
            check({tag, " valid_after"}, 32'(o_valid), 0);
            check({tag, " busy_after"}, 32'(o_busy), 0);
            check({tag, " latency"}, edges, exp_lat);
        end
    endtask

    task automatic end_frame(input string tag);
        drive(1'b0, 1'b1);
        step();
        check({tag, " idle_done"}, 32'(o_done), 0);
        check({tag, " idle_busy"}, 32'(o_busy), 0);
        check({tag, " idle_valid"}, 32'(o_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        en_a = 1'b0; rdy_a = 1'b0;
        en_b = 1'b0; rdy_b = 1'b0;
        map_a = '{'{8'd1, 8'd2}, '{8'd3, 8'd4}};
        map_b = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}, '{8'd7, 8'd8, 8'd9}};
        repeat (2) step();

        check("rst valid", 32'(valid_a), 0);
        check("rst data", 32'(data_a), 0);
        check("rst row", 32'(row_a), 0);
        check("rst col", 32'(col_a), 0);
        check("rst last", 32'(last_a), 0);
        check("rst busy", 32'(busy_a), 0);
        check("rst done", 32'(done_a), 0);
        check("rst valid_b", 32'(valid_b), 0);
        reset = 1'b0;
        step();

        // 2x2 -> 4x4 expected raster
        side = 4;
        exp_pix = '{1,1,2,2, 1,1,2,2, 3,3,4,4, 3,3,4,4, 0,0,0,0,0,0,0,0,0};
        run_frame("t1", 16, 0, 1'b0, 0, 18);
        end_frame("t1");

        // 16 handshakes at cyc 0,3,...,45 -> 30 stalls, 2 + 46 edges
        run_frame("t3", 16, 1, 1'b0, 0, 48);
        end_frame("t3");

        run_frame("t4", 16, 0, 1'b1, 0, 18);
        end_frame("t4");
        map_a = '{'{8'd1, 8'd2}, '{8'd3, 8'd4}};

        run_frame("t5", 16, 0, 1'b0, 5, 0);
        drive(1'b0, 1'b1);
        step();
        check("t5 abort_valid", 32'(valid_a), 0);
        check("t5 abort_busy", 32'(busy_a), 0);
        check("t5 abort_done", 32'(done_a), 0);
        step();
        check("t5 abort_done2", 32'(done_a), 0);
        run_frame("t5r", 16, 0, 1'b0, 0, 18);
        end_frame("t5r");

        // Pixel 3 is (0,3) = 2 when the asynchronous reset hits.
        drive(1'b1, 1'b1);
        repeat (5) step();
        check("t6 pre_data", 32'(data_a), 2);
        check("t6 pre_col", 32'(col_a), 3);
        check("t6 pre_valid", 32'(valid_a), 1);
        #2 reset = 1'b1;
        #1;
        check("t6 async_valid", 32'(valid_a), 0);
        check("t6 async_data", 32'(data_a), 0);
        check("t6 async_row", 32'(row_a), 0);
        check("t6 async_col", 32'(col_a), 0);
        check("t6 async_last", 32'(last_a), 0);
        check("t6 async_busy", 32'(busy_a), 0);
        check("t6 async_done", 32'(done_a), 0);
        drive(1'b0, 1'b0);
        repeat (2) step();
        reset = 1'b0;
        step();
        check("t6 idle_valid", 32'(valid_a), 0);
        check("t6 idle_busy", 32'(busy_a), 0);
        run_frame("t6", 16, 0, 1'b0, 0, 18);
        end_frame("t6");

        // 3x3 -> 5x5 cropped raster
        sel_b = 1'b1;
        side = 5;
        exp_pix = '{1,1,2,2,3, 1,1,2,2,3, 4,4,5,5,6, 4,4,5,5,6, 7,7,8,8,9};
        run_frame("t2", 25, 0, 1'b0, 0, 27);
        end_frame("t2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
